// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one request/grant read per PC and buffers
// returned words, tagged with their PC, in a small FIFO toward decode.
module ifetch_unit #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp} state_e;

  state_e            r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_drop;

  logic [31:0]       r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_credit_idle;
  logic              w_credit_rsp;
  logic [ADDR_W-1:0] w_aligned;

  assign w_aligned   = {pc[ADDR_W-1:2], 2'b00};
  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  assign w_push      = (r_state == StWaitRsp) & imem_rvalid & ~r_drop & ~flush;

  // Credit ignores a same-cycle pop; the response being pushed now counts as buffered.
  assign w_credit_idle = (r_count < DepthC);
  assign w_credit_rsp  = ((r_count + CW'(w_push)) < DepthC);

  // A dropped fetch must not advance the PC past a pending redirect target.
  assign pc_en     = r_req & imem_gnt & ~flush & ~r_drop;
  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instr     = r_mem_data[r_rptr];
  assign instr_pc  = r_mem_pc[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_req_pc <= '0;
      r_drop   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_credit_idle && !flush) begin
            r_state  <= StReq;
            r_req    <= 1'b1;
            r_addr   <= w_aligned;
            r_req_pc <= pc;
          end
        end
        StReq: begin
          if (flush) r_drop <= 1'b1;
          if (imem_gnt) begin
            r_state <= StWaitRsp;
            r_req   <= 1'b0;
          end
        end
        StWaitRsp: begin
          if (imem_rvalid) begin
            r_drop <= 1'b0;
            // A flush here means pc is stale until the redirect lands; refetch from idle.
            if (w_credit_rsp && !flush) begin
              r_state  <= StReq;
              r_req    <= 1'b1;
              r_addr   <= w_aligned;
              r_req_pc <= pc;
            end else begin
              r_state <= StIdle;
            end
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= imem_rdata;
        r_mem_pc[r_wptr]   <= r_req_pc;
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program-counter register.
- Each cycle it takes the current `pc` and issues a request/grant read to instruction memory.
- It returns the PC-register load enable and buffers fetched words, tagged with their PC, in a small FIFO toward decode.
- Redirects (branch/jump/exception) flush buffered and in-flight fetches.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- ADDR_W, 32, PC/address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- pc  in  ADDR_W  current PC from PC register
- pc_en  out  1  PC register may load nextpc this cycle
- flush  in  1  redirect; discard all buffered/in-flight fetches
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  word-aligned request address
- imem_gnt  in  1  request accepted (may coincide with imem_req)
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction word
- instr_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; FIFO count=0; drop flag=0.
  - All outputs 0, including imem_addr, instr and instr_pc.
- Credit rule: a request may start only when count + outstanding < DEPTH.
  - Count is sampled at the clock edge; a pop in the same cycle is not credited until the next cycle.
  - At most 1 request outstanding.
- State IDLE:
  - If credit is available and flush=0 → REQ.
  - On entry, latch req_addr = {pc[ADDR_W-1:2],2'b00} and req_pc = pc.
- State REQ:
  - imem_req=1; imem_addr=req_addr, held stable until gnt, even if pc or flush change.
  - On imem_gnt: pc_en=1 for that cycle only if flush=0, then → WAIT_RSP.
  - If flush=1 in the grant cycle: set drop=1 and → WAIT_RSP.
  - If flush=1 with no grant: keep the request, set drop=1.
- State WAIT_RSP:
  - On imem_rvalid with drop=0: push {imem_rdata, req_pc}.
  - On imem_rvalid with drop=1: discard the data and clear drop.
  - Next state: REQ if credit is available (relatch addr/pc from current pc), else IDLE.
  - flush while waiting sets drop=1.
- pc_en is 1 only in a non-flush grant cycle; otherwise 0. The external redirect path owns PC loading on flush.
- imem_rvalid outside WAIT_RSP is ignored (protocol violation, no push).
- FIFO:
  - instr_valid = count≠0; instr/instr_pc show the head entry (registered storage, no combinational path from imem_rdata).
  - Pop when instr_valid & instr_ready.
  - Simultaneous push+pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the credit rule.
- flush=1: FIFO count→0 next cycle (flush wins over push/pop); instr_valid=0 next cycle.
- Throughput with 0-wait memory (gnt with req, rvalid next cycle):
  - Req at T, instruction visible at T+2, next req at T+2.
  - One instruction per 2 cycles.
- Reset mid-transaction: everything cleared immediately; a later rvalid lands in IDLE/REQ and is ignored.

Test Plan:
- Reset, then rst=1, pc=0x0000_0000, 0-wait memory returning addr+0x100, instr_ready=1:
  - imem_req=1 at cycle 1 with addr 0x0, pc_en=1 at cycle 1.
  - instr_valid at cycle 3 with instr=0x100, instr_pc=0x0.
  - Subsequent fetches every 2 cycles.
- instr_ready=0, pc stepping +4:
  - Exactly 2 instructions (pc 0x0, 0x4) buffered, then imem_req stays 0 and pc_en stays 0.
  - instr_ready=1 drains them in order, then fetching resumes.
- pc=0x0000_0006:
  - imem_addr=0x0000_0004; instr_pc=0x0000_0006.
- gnt delayed 3 cycles while pc changes externally:
  - imem_addr stable for all 4 request cycles; pc_en=1 only in the grant cycle.
- flush asserted in WAIT_RSP, rvalid returns 0xDEAD_BEEF 2 cycles later:
  - No push; FIFO empty; pc_en=0 during the flush cycle.
  - Next request uses the redirected pc (e.g. 0x0000_0200).
- rst=0 asserted asynchronously mid-WAIT_RSP, released 1 cycle later; stray rvalid arrives in IDLE:
  - All outputs 0 immediately; stray data not pushed.
  - Normal fetch from current pc afterwards.
